// File: rtl/multi_echo_proc_if.sv
// Sample-side bus of the echo processor: ADC strobe, controls and sample in, DAC sample out.
interface multi_echo_proc_if #(
  parameter int unsigned DW  = 10,
  parameter int unsigned RDW = 9
);
  logic           valid;
  logic [1:0]     mode;
  logic [RDW-1:0] rdelay;
  logic [2:0]     atten;
  logic [DW-1:0]  data_in;
  logic [DW-1:0]  data_out;
  logic           dout_valid;

  modport master (
    output valid, mode, rdelay, atten, data_in,
    input  data_out, dout_valid
  );

  modport slave (
    input  valid, mode, rdelay, atten, data_in,
    output data_out, dout_valid
  );
endinterface

// File: rtl/multi_echo_proc.sv
// Per-sample echo processor: circular delay buffer with programmable delay, attenuation,
// bypass/feed-forward/feedback modes, saturating arithmetic and a buffer-fill guard.
module multi_echo_proc #(
  parameter int unsigned    DW         = 10,
  parameter int unsigned    AW         = 13,
  parameter int unsigned    RDW        = 9,
  parameter int unsigned    STEP_LOG2  = 4,
  parameter logic [DW-1:0]  ADC_OFFSET = DW'(10'h181),
  parameter logic [DW-1:0]  DAC_OFFSET = DW'(10'h200)
) (
  input  logic            sysclk,
  input  logic            rst,
  multi_echo_proc_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned SW    = DW + 1;
  localparam int unsigned FW    = AW + 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  localparam logic [DW-1:0] SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CALC
  } state_t;

  state_t state_q, state_d;
  logic   latch_en, read_en, commit_en;

  logic [2:0]            sync_q;
  logic                  sp_c;
  logic signed [DW-1:0]  x_q;
  logic [1:0]            mode_q;
  logic [2:0]            atten_q;
  logic [AW-1:0]         d_q;
  logic [AW-1:0]         wr_ptr;
  logic [FW-1:0]         fill_cnt;
  logic [DW-1:0]         q_q;
  logic [DW-1:0]         mem [DEPTH];

  logic [31:0]           d_raw_c;
  logic [AW-1:0]         d_c;
  logic signed [DW-1:0]  x_c;
  logic [AW-1:0]         rd_addr_c;
  logic signed [DW-1:0]  e_c;
  logic signed [SW-1:0]  x_ext_c, e_ext_c, sum_c;
  logic signed [DW-1:0]  y_c;
  logic [DW-1:0]         wr_data_c;

  // Two-FF synchroniser plus an edge-history bit for the asynchronous ADC strobe
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], bus.valid};
  end

  assign sp_c = sync_q[1] & ~sync_q[2];

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Pipeline sequencing: latch (c0), RAM read (c1), compute/write/output (c2)
  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    read_en   = 1'b0;
    commit_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sp_c) begin
          latch_en = 1'b1;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        read_en = 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        commit_en = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delay in samples, clamped to the usable range of the buffer
  always_comb begin
    d_raw_c = 32'(bus.rdelay) << STEP_LOG2;
    if (d_raw_c == 32'd0)             d_c = AW'(1);
    else if (d_raw_c >= 32'(DEPTH))   d_c = AW'(DEPTH - 1);
    else                              d_c = AW'(d_raw_c);
  end

  assign x_c       = $signed(bus.data_in - ADC_OFFSET);
  assign rd_addr_c = wr_ptr - d_q;

  // Echo term, muted until the buffer holds d samples written under the current delay
  always_comb begin
    e_c = '0;
    if (fill_cnt >= FW'(d_q)) e_c = $signed(q_q) >>> atten_q;
  end

  always_comb begin
    x_ext_c = {x_q[DW-1], x_q};
    e_ext_c = {e_c[DW-1], e_c};
    sum_c   = x_ext_c;
    unique case (mode_q)
      2'd0:    sum_c = x_ext_c;
      2'd1:    sum_c = x_ext_c + e_ext_c;
      2'd2:    sum_c = x_ext_c + e_ext_c;
      default: sum_c = x_ext_c - e_ext_c;
    endcase
    if (sum_c[SW-1] != sum_c[SW-2]) y_c = sum_c[SW-1] ? SAT_MIN : SAT_MAX;
    else                            y_c = sum_c[DW-1:0];
    wr_data_c = mode_q[1] ? y_c : x_q;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      x_q            <= '0;
      mode_q         <= '0;
      atten_q        <= '0;
      d_q            <= '0;
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      bus.data_out   <= DAC_OFFSET;
      bus.dout_valid <= 1'b0;
    end else begin
      bus.dout_valid <= commit_en;
      if (latch_en) begin
        x_q     <= x_c;
        mode_q  <= bus.mode;
        atten_q <= bus.atten;
        d_q     <= d_c;
        if (d_c != d_q) fill_cnt <= '0;
      end
      if (commit_en) begin
        wr_ptr       <= wr_ptr + AW'(1);
        bus.data_out <= y_c + DAC_OFFSET;
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + FW'(1);
      end
    end
  end

  // Delay RAM is deliberately not reset; the fill guard hides stale contents
  always_ff @(posedge sysclk) begin
    if (read_en)   q_q <= mem[rd_addr_c];
    if (commit_en) mem[wr_ptr] <= wr_data_c;
  end

endmodule

// File: tb/tb_multi_echo_proc.sv
// Randomised scoreboard bench for multi_echo_proc; a small buffer (AW=8) makes the
// delay clamp, wrap-around and fill guard reachable in a short run.
module tb_multi_echo_proc;

  localparam int unsigned DW        = 10;
  localparam int unsigned AW        = 8;
  localparam int unsigned RDW       = 9;
  localparam int unsigned STEP_LOG2 = 4;
  localparam int          DEPTH     = 1 << AW;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  multi_echo_proc_if #(.DW(DW), .RDW(RDW)) bus ();

  multi_echo_proc #(.DW(DW), .AW(AW), .RDW(RDW), .STEP_LOG2(STEP_LOG2)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    logic [9:0] data;
    int         t;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  // Reference model state: every value written since reset, in sample order
  int hist[$];
  int change_idx = 0;
  int prev_d     = -1;

  always @(posedge sysclk) cyc++;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act == want) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
  endtask

  task automatic model_reset();
    hist.delete();
    change_idx = 0;
    prev_d     = -1;
  endtask

  task automatic model(input int mode, input int rdelay, input int atten, input int din,
                       output logic [9:0] want);
    int dv, x, e, n, y;
    dv = rdelay * (1 << STEP_LOG2);
    if (dv == 0) dv = 1;
    else if (dv >= DEPTH) dv = DEPTH - 1;
    if (dv != prev_d) begin
      change_idx = hist.size();
      prev_d     = dv;
    end
    n = hist.size();
    e = (n - change_idx >= dv) ? (hist[n - dv] >>> atten) : 0;
    x = (din - 385) & 1023;
    if (x >= 512) x -= 1024;
    case (mode)
      0:       y = x;
      1, 2:    y = x + e;
      default: y = x - e;
    endcase
    if (y > 511)  y = 511;
    if (y < -512) y = -512;
    hist.push_back(mode >= 2 ? y : x);
    want = 10'((y + 512) & 1023);
  endtask

  // Monitor: pops one expectation per output strobe
  always @(negedge sysclk) begin
    if (!rst && bus.dout_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_dout_valid: got pulse data_out=0x%0h expected none (cycle %0d)",
                 bus.data_out, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("data_out", int'(bus.data_out), int'(e.data));
        checks++;
        if ((cyc - e.t) >= 5 && (cyc - e.t) <= 6) passed++;
        else $display("FAIL latency: got %0d cycles expected 5..6", cyc - e.t);
      end
    end
  end

  task automatic send(input int mode, input int rdelay, input int atten, input int din);
    logic [9:0] want;
    @(negedge sysclk);
    bus.mode    = 2'(mode);
    bus.rdelay  = RDW'(rdelay);
    bus.atten   = 3'(atten);
    bus.data_in = DW'(din);
    bus.valid   = 1'b1;
    model(mode, rdelay, atten, din, want);
    sbq.push_back('{want, cyc});
    repeat (4) @(negedge sysclk);
    bus.valid = 1'b0;
    repeat (3) @(negedge sysclk);
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 50) begin
      @(negedge sysclk);
      k++;
    end
    check("drain_pending", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic do_reset();
    drain();
    @(negedge sysclk);
    rst       = 1'b1;
    bus.valid = 1'b0;
    model_reset();
    repeat (2) @(negedge sysclk);
    check("reset_data_out", int'(bus.data_out), 'h200);
    check("reset_dout_valid", int'(bus.dout_valid), 0);
    rst = 1'b0;
    repeat (3) @(negedge sysclk);
  endtask

  initial begin
    int pulses;
    int rd;
    bus.valid   = 1'b0;
    bus.mode    = '0;
    bus.rdelay  = '0;
    bus.atten   = '0;
    bus.data_in = '0;
    do_reset();

    // Bypass
    for (int i = 0; i < 10; i++) send(0, $urandom_range(0, 3), $urandom_range(0, 7), 'h181 + 100);

    // Feed-forward impulse
    do_reset();
    send(1, 1, 1, 'h181 + 200);
    for (int i = 0; i < 39; i++) send(1, 1, 1, 'h181);

    // Feedback decay
    do_reset();
    send(2, 1, 1, 'h181 + 200);
    for (int i = 0; i < 79; i++) send(2, 1, 1, 'h181);

    // Saturation both directions
    do_reset();
    for (int i = 0; i < 40; i++) send(1, 1, 0, 'h181 + 400);
    for (int i = 0; i < 40; i++) send(1, 1, 0, 'h181 - 400);

    // Clamp to DEPTH-1 and fill guard, then delay change mid-run
    do_reset();
    for (int i = 0; i < 300; i++) send(1, 'h1FF, $urandom_range(0, 2), $urandom_range(0, 1023));
    for (int i = 0; i < 40; i++) send(1, 16, 0, $urandom_range(0, 1023));
    for (int i = 0; i < 60; i++) send(1, 2, 0, $urandom_range(0, 1023));
    for (int i = 0; i < 30; i++) send(3, 0, $urandom_range(0, 3), $urandom_range(0, 1023));

    // Reset in c1 aborts the sample in flight
    drain();
    send(0, 1, 0, 'h181 + 100);
    drain();
    @(negedge sysclk);
    bus.mode    = 2'd1;
    bus.data_in = DW'('h181 + 50);
    bus.valid   = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_data_out", int'(bus.data_out), 'h200);
    check("abort_dout_valid", int'(bus.dout_valid), 0);
    @(negedge sysclk);
    bus.valid = 1'b0;
    model_reset();
    repeat (3) @(negedge sysclk);
    rst    = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge sysclk);
      if (bus.dout_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    for (int i = 0; i < 24; i++) send(1, 1, 0, $urandom_range(0, 1023));

    // Random traffic with occasional delay changes
    rd = 1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 5))
          0: rd = 0;
          1: rd = 1;
          2: rd = 2;
          3: rd = 3;
          4: rd = 15;
          default: rd = 16;
        endcase
      end
      send($urandom_range(0, 3), rd, $urandom_range(0, 7), $urandom_range(0, 1023));
    end

    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
